// File: rtl/part_pkg.sv
// Shared types for the partitioned-simulation data exchange (initiator and target sides).
package part_pkg;

    localparam int NUM_CLOCKS = 4;
    localparam int REC_W      = 9;

    typedef enum logic [1:0] {
        data_clk_0,
        data_clk_1,
        data_clk_2,
        data_clk_3
    } data_clk_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        APPLY,
        RELEASE
    } rcv_state_t;

    // Bit REC_W-1 is the write-enable, the rest is payload data.
    typedef struct packed {
        logic             wen;
        logic [REC_W-2:0] data;
    } rec_t;

endpackage

// File: rtl/part_watchdog.sv
// 16-bit up-counter with synchronous clear; expire flags the cycle the count sits at LIMIT-1.
module part_watchdog #(
    parameter int LIMIT = 1
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign expire = (count_reg == LAST);

endmodule

// File: rtl/part_1_init_rcv_seq.sv
// Initiator receive sequencer: freeze the partition, collect one record per announced
// mission clock, apply them all in one cycle, then hold the freeze for STRETCH cycles.
module part_1_init_rcv_seq
    import part_pkg::*;
#(
    parameter int N       = REC_W,
    parameter int TIMEOUT = 1000,
    parameter int STRETCH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         exch_start,
    input  logic [3:0]   exp_mask,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [1:0]   rx_clk_id,
    input  logic [N-1:0] rx_data,
    output logic [3:0]   freeze_clk,
    output logic         wen0,
    output logic         wen1,
    output logic         wen2,
    output logic [7:0]   i_data0,
    output logic [7:0]   i_data1,
    output logic [7:0]   i_data2,
    output logic         up_valid,
    output logic [N-1:0] up_data,
    output logic         done,
    output logic         err_unexp,
    output logic         err_busy,
    output logic         err_timeout
);

    localparam int REL_LIMIT = (STRETCH < 1) ? 1 : STRETCH;

    rcv_state_t             state_reg, state_next;
    logic [NUM_CLOCKS-1:0]  pend_mask_reg, pend_next;
    logic [NUM_CLOCKS-1:0]  got_mask_reg, got_next;
    rec_t                   slot_reg [NUM_CLOCKS];
    logic                   wen_reg [3];
    logic [7:0]             i_data_reg [3];
    logic [N-1:0]           up_data_reg;
    logic                   applied_reg;
    logic                   up_valid_reg, done_reg;
    logic                   err_unexp_reg, err_busy_reg, err_timeout_reg;
    logic                   accept, hit, timeout_hit;
    logic                   wd_exp, rel_exp;

    assign rx_ready   = (state_reg == COLLECT);
    assign freeze_clk = (state_reg == IDLE) ? 4'h0 : 4'hf;
    assign accept     = rx_valid && rx_ready;
    assign hit        = pend_mask_reg[rx_clk_id];

    part_watchdog #(.LIMIT(TIMEOUT)) u_wd (
        .clk    (clk_i),
        .srst   (rst_i),
        .clear  (state_reg == IDLE),
        .enable (state_reg == COLLECT),
        .expire (wd_exp)
    );

    part_watchdog #(.LIMIT(REL_LIMIT)) u_rel (
        .clk    (clk_i),
        .srst   (rst_i),
        .clear  (state_reg != RELEASE),
        .enable (state_reg == RELEASE),
        .expire (rel_exp)
    );

    always_comb begin
        state_next  = state_reg;
        pend_next   = pend_mask_reg;
        got_next    = got_mask_reg;
        timeout_hit = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (exch_start && (exp_mask != '0)) begin
                    state_next = COLLECT;
                    pend_next  = exp_mask;
                    got_next   = '0;
                end
            end
            COLLECT: begin
                if (accept && hit) begin
                    pend_next[rx_clk_id] = 1'b0;
                    got_next[rx_clk_id]  = 1'b1;
                end
                // Completion is checked first so a last-cycle arrival beats the timeout.
                if (pend_next == '0) begin
                    state_next = APPLY;
                end else if (wd_exp) begin
                    state_next  = RELEASE;
                    timeout_hit = 1'b1;
                end
            end
            APPLY:   state_next = RELEASE;
            RELEASE: if (rel_exp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            pend_mask_reg   <= '0;
            got_mask_reg    <= '0;
            applied_reg     <= 1'b0;
            up_data_reg     <= '0;
            up_valid_reg    <= 1'b0;
            done_reg        <= 1'b0;
            err_unexp_reg   <= 1'b0;
            err_busy_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pend_mask_reg   <= pend_next;
            got_mask_reg    <= got_next;
            err_unexp_reg   <= accept && !hit;
            err_busy_reg    <= exch_start && (state_reg != IDLE);
            err_timeout_reg <= timeout_hit;
            up_valid_reg    <= (state_reg == APPLY) && got_mask_reg[3];
            // Timed-out exchanges pass through RELEASE too, but must not report done.
            done_reg        <= (state_reg == RELEASE) && rel_exp && applied_reg;
            if (state_reg == APPLY) begin
                applied_reg <= 1'b1;
                if (got_mask_reg[3]) begin
                    up_data_reg <= slot_reg[3];
                end
            end else if (state_reg == IDLE) begin
                applied_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                slot_reg[gi] <= '0;
            end else if (accept && hit && (rx_clk_id == 2'(gi))) begin
                slot_reg[gi] <= rec_t'(rx_data);
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_pin
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wen_reg[gi]    <= 1'b0;
                i_data_reg[gi] <= '0;
            end else if ((state_reg == APPLY) && got_mask_reg[gi]) begin
                wen_reg[gi]    <= slot_reg[gi].wen;
                i_data_reg[gi] <= slot_reg[gi].data;
            end
        end
    end

    assign wen0        = wen_reg[0];
    assign wen1        = wen_reg[1];
    assign wen2        = wen_reg[2];
    assign i_data0     = i_data_reg[0];
    assign i_data1     = i_data_reg[1];
    assign i_data2     = i_data_reg[2];
    assign up_data     = up_data_reg;
    assign up_valid    = up_valid_reg;
    assign done        = done_reg;
    assign err_unexp   = err_unexp_reg;
    assign err_busy    = err_busy_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_part_1_init_rcv_seq.sv
// Self-checking bench: directed and random exchanges against a transaction-level model.
module tb_part_1_init_rcv_seq;

    localparam int N  = 9;
    localparam int TO = 8;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         exch_start;
    logic [3:0]   exp_mask;
    logic         rx_valid;
    logic         rx_ready;
    logic [1:0]   rx_clk_id;
    logic [N-1:0] rx_data;
    logic [3:0]   freeze_clk;
    logic         wen0, wen1, wen2;
    logic [7:0]   i_data0, i_data1, i_data2;
    logic         up_valid;
    logic [N-1:0] up_data;
    logic         done;
    logic         err_unexp, err_busy, err_timeout;

    int total = 0;
    int bad   = 0;

    // Expected pin levels: slots 0..2 as {wen,data}, plus the upload record.
    logic [8:0] pin_exp [3];
    logic [8:0] up_exp;

    always #5 clk = ~clk;

    part_1_init_rcv_seq #(.N(N), .TIMEOUT(TO), .STRETCH(ST)) dut (
        .clk_i(clk), .rst_i(rst_i), .exch_start(exch_start), .exp_mask(exp_mask),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_clk_id(rx_clk_id), .rx_data(rx_data),
        .freeze_clk(freeze_clk), .wen0(wen0), .wen1(wen1), .wen2(wen2),
        .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2),
        .up_valid(up_valid), .up_data(up_data), .done(done),
        .err_unexp(err_unexp), .err_busy(err_busy), .err_timeout(err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rec(input logic [1:0] id, input logic [8:0] data);
        return {1'b1, id, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_pins(input string tag);
        check({tag, ".wen0"}, 32'(wen0), 32'(pin_exp[0][8]));
        check({tag, ".wen1"}, 32'(wen1), 32'(pin_exp[1][8]));
        check({tag, ".wen2"}, 32'(wen2), 32'(pin_exp[2][8]));
        check({tag, ".i_data0"}, 32'(i_data0), 32'(pin_exp[0][7:0]));
        check({tag, ".i_data1"}, 32'(i_data1), 32'(pin_exp[1][7:0]));
        check({tag, ".i_data2"}, 32'(i_data2), 32'(pin_exp[2][7:0]));
        check({tag, ".up_data"}, 32'(up_data), 32'(up_exp));
    endtask

    // One exchange: recs holds {valid,id,data} per cycle after exch_start.
    task automatic run_exchange(input string name, input logic [3:0] mask,
                                input logic [11:0] recs[$], input bit busy_in_release);
        logic [3:0]  pend;
        logic [3:0]  got;
        logic [8:0]  slot [4];
        logic [11:0] r;
        int          j;
        int          n_unexp;
        bit          finished;
        bit          timed_out;
        bit          exp_unexp;
        pend = mask; got = '0; n_unexp = 0;
        for (int i = 0; i < 4; i++) slot[i] = '0;
        exch_start = 1'b1; exp_mask = mask; rx_valid = 1'b0;
        tick();
        exch_start = 1'b0; exp_mask = 4'($urandom);
        check({name, ".freeze_start"}, 32'(freeze_clk), 32'hf);
        check({name, ".ready_start"}, 32'(rx_ready), 32'd1);
        j = 0; finished = 1'b0; timed_out = 1'b0;
        while (!finished && !timed_out) begin
            r = (recs.size() > 0) ? recs.pop_front() : 12'h0;
            rx_valid = r[11]; rx_clk_id = r[10:9]; rx_data = r[8:0];
            tick();
            j++;
            exp_unexp = 1'b0;
            if (r[11]) begin
                if (pend[r[10:9]]) begin
                    slot[r[10:9]] = r[8:0];
                    pend[r[10:9]] = 1'b0;
                    got[r[10:9]]  = 1'b1;
                end else begin
                    exp_unexp = 1'b1;
                    n_unexp++;
                end
            end
            if (pend == 4'h0) finished = 1'b1;
            else if (j == TO) timed_out = 1'b1;
            check({name, ".err_unexp"}, 32'(err_unexp), 32'(exp_unexp));
            check({name, ".err_timeout"}, 32'(err_timeout), 32'(timed_out));
            check({name, ".rx_ready"}, 32'(rx_ready), 32'(!(finished || timed_out)));
            check({name, ".freeze_collect"}, 32'(freeze_clk), 32'hf);
            check({name, ".done_collect"}, 32'(done), 32'd0);
            check({name, ".up_valid_collect"}, 32'(up_valid), 32'd0);
        end
        // Offer a record after COLLECT; it must be ignored.
        rx_valid = 1'b1; rx_clk_id = 2'($urandom); rx_data = 9'($urandom);
        if (finished) begin
            tick();
            for (int i = 0; i < 3; i++) if (got[i]) pin_exp[i] = slot[i];
            if (got[3]) up_exp = slot[3];
            check_pins({name, ".apply"});
            check({name, ".up_valid"}, 32'(up_valid), 32'(got[3]));
            check({name, ".freeze_apply"}, 32'(freeze_clk), 32'hf);
            check({name, ".err_unexp_apply"}, 32'(err_unexp), 32'd0);
            if (busy_in_release) begin
                exch_start = 1'b1; exp_mask = 4'hf;
            end
            tick();
            exch_start = 1'b0;
            check({name, ".err_busy"}, 32'(err_busy), 32'(busy_in_release));
            check({name, ".done_early"}, 32'(done), 32'd0);
            check({name, ".freeze_rel"}, 32'(freeze_clk), 32'hf);
            tick();
            rx_valid = 1'b0;
            check({name, ".done"}, 32'(done), 32'd1);
            check({name, ".freeze_end"}, 32'(freeze_clk), 32'h0);
            check({name, ".ready_end"}, 32'(rx_ready), 32'd0);
            tick();
            check({name, ".done_drop"}, 32'(done), 32'd0);
            check_pins({name, ".after"});
        end else begin
            tick();
            rx_valid = 1'b0;
            check({name, ".freeze_rel"}, 32'(freeze_clk), 32'hf);
            check({name, ".err_timeout_drop"}, 32'(err_timeout), 32'd0);
            tick();
            check({name, ".freeze_end"}, 32'(freeze_clk), 32'h0);
            check({name, ".no_done"}, 32'(done), 32'd0);
            tick();
            check({name, ".no_done_late"}, 32'(done), 32'd0);
            check_pins({name, ".unchanged"});
        end
        $display("%s: mask=%h got=%h unexp=%0d timeout=%0d cycles=%0d", name, mask, got,
                 n_unexp, timed_out, j);
    endtask

    initial begin
        logic [11:0] q[$];
        logic [3:0]  m;
        rst_i = 1'b1; exch_start = 1'b0; exp_mask = '0;
        rx_valid = 1'b0; rx_clk_id = '0; rx_data = '0;
        for (int i = 0; i < 3; i++) pin_exp[i] = '0;
        up_exp = '0;
        tick();
        check("reset.freeze", 32'(freeze_clk), 32'h0);
        check("reset.ready", 32'(rx_ready), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check_pins("reset");
        rst_i = 1'b0;
        tick();

        // exp_mask of zero is ignored without error.
        exch_start = 1'b1; exp_mask = 4'h0;
        tick();
        exch_start = 1'b0;
        check("zero_mask.freeze", 32'(freeze_clk), 32'h0);
        check("zero_mask.ready", 32'(rx_ready), 32'd0);
        check("zero_mask.busy", 32'(err_busy), 32'd0);
        $display("zero_mask: ignored");

        q = {rec(2'd0, 9'h1aa), rec(2'd1, 9'h155), rec(2'd2, 9'h133), rec(2'd3, 9'h1ff)};
        run_exchange("full", 4'hf, q, 1'b0);

        q = {rec(2'd2, 9'h033), rec(2'd2, 9'h044), rec(2'd0, 9'h101)};
        run_exchange("dup", 4'b0101, q, 1'b0);

        q = {rec(2'd0, 9'h0c3)};
        run_exchange("timeout", 4'b0011, q, 1'b0);

        q = {rec(2'd1, 9'h1e7)};
        run_exchange("busy", 4'b0010, q, 1'b1);

        q = {12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, rec(2'd3, 9'h0a5)};
        run_exchange("last_cycle", 4'b1000, q, 1'b0);

        // Reset in the middle of COLLECT.
        exch_start = 1'b1; exp_mask = 4'b0011;
        tick();
        exch_start = 1'b0;
        rx_valid = 1'b1; rx_clk_id = 2'd0; rx_data = 9'h17e;
        tick();
        rx_valid = 1'b0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) pin_exp[i] = '0;
        up_exp = '0;
        check("midrst.freeze", 32'(freeze_clk), 32'h0);
        check("midrst.ready", 32'(rx_ready), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.err_timeout", 32'(err_timeout), 32'd0);
        check_pins("midrst");
        $display("midrst: reset during collect");
        tick();
        q = {rec(2'd1, 9'h12d), rec(2'd0, 9'h0f0)};
        run_exchange("post_rst", 4'b0011, q, 1'b0);

        for (int t = 0; t < 25; t++) begin
            m = 4'($urandom_range(1, 15));
            q = {};
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 3) != 0) q.push_back(rec(2'($urandom), 9'($urandom)));
                else q.push_back(12'h0);
            end
            run_exchange($sformatf("rand%0d", t), m, q, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/part_1_init_rcv_seq.md
# part_1_init_rcv_seq

Initiator-side receive sequencer for the partitioned-simulation data exchange. The target side samples mission-clock edges, freezes clocks and ships one 9-bit record per active mission clock. This block is the matching receiving end. It freezes its partition, collects the record expected for each announced clock, applies all of them to the partition's input pins in a single cycle, then releases the freeze after a stretch delay. It sits between the fringe transport (abstracted as a valid/ready stream) and the partition's download/upload pins.

## Interface
- N, 9, record width; bit N-1 is the write-enable, bits N-2:0 are data (8 bits).
- TIMEOUT, 1000, max cycles spent in COLLECT before abort; 16-bit counter, legal range 2..65535.
- STRETCH, 2, cycles freeze_clk stays high after APPLY.

Ports:
- clk_i  in  1  utility clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- exch_start  in  1  one-cycle pulse that opens an exchange.
- exp_mask  in  4  expected mission clocks (bit i = data_clk_i); sampled with exch_start.
- rx_valid  in  1  record present.
- rx_ready  out  1  record accepted when rx_valid & rx_ready.
- rx_clk_id  in  2  mission clock the record belongs to.
- rx_data  in  N  record payload.
- freeze_clk  out  4  freeze for mission clocks 3..0.
- wen0, wen1, wen2  out  1 each  downloaded enables (slots 0..2).
- i_data0, i_data1, i_data2  out  8 each  downloaded data (slots 0..2).
- up_valid  out  1  one-cycle pulse; slot-3 record applied.
- up_data  out  N  slot-3 record.
- done  out  1  one-cycle pulse; exchange finished.
- err_unexp  out  1  pulse; record for a clock that is not pending was dropped.
- err_busy  out  1  pulse; exch_start arrived outside IDLE.
- err_timeout  out  1  pulse; COLLECT aborted.

## Operation
- States: IDLE, COLLECT, APPLY, RELEASE.
- **IDLE:** rx_ready=0, freeze_clk=0.
  - exch_start with exp_mask≠0: latch pend_mask=rcv_mask_exp=exp_mask, clear got_mask, wd=0, freeze_clk←4'hf, go to COLLECT.
  - exch_start with exp_mask=0: ignored, no error.
- **COLLECT:** rx_ready=1; wd increments each cycle.
  - Accepted record with pend_mask[id]=1: slot[id]←rx_data, clear pend_mask[id], set got_mask[id].
  - Accepted record with pend_mask[id]=0 (duplicate or unexpected id): err_unexp pulse, record dropped.
  - pend_mask reaches 0, including via an accept in the same cycle: go to APPLY.
  - wd == TIMEOUT-1 and pend_mask still nonzero after this cycle's accept: err_timeout pulse, go to RELEASE. Slots are not applied and pins keep their old values.
  - Completion in the same cycle as the timeout: completion wins, no error.
- **APPLY (one cycle), for each i with got_mask[i]=1:**
  - i in 0..2: wen_i←slot[i][N-1], i_data_i←slot[i][7:0].
  - i=3: up_data←slot[3], up_valid pulse.
  - Slots not received keep their previous pin values.
  - Then go to RELEASE with rel_cnt=0.
- **RELEASE:** freeze_clk stays 4'hf; rel_cnt increments.
  - When rel_cnt == STRETCH-1: freeze_clk←0, done pulse, go to IDLE.
  - STRETCH=0 is treated as 1.
- **Any state:** exch_start outside IDLE gives an err_busy pulse and is otherwise ignored.
- **Pins:** wen/i_data are levels held until the next APPLY that writes that slot.

## Timing
- Reset (rst_i=1 at an edge) gives, at that edge:
  - state=IDLE;
  - all outputs 0, freeze_clk=0, up_data=0;
  - slots, masks and counters 0.
- Reset mid-exchange aborts immediately, with no done and no error pulse.
- exch_start at edge k:
  - freeze_clk=4'hf and rx_ready=1 from edge k.
  - The earliest accept is at edge k+1.
- Last pending record accepted at edge a:
  - APPLY during cycle a..a+1.
  - Pins and up_valid update at edge a+1.
  - freeze_clk falls and done rises at edge a+1+STRETCH; done drops one cycle later.
- rx_ready deasserts at the edge that leaves COLLECT; no record is accepted in APPLY, RELEASE or IDLE.
- Timeout: err_timeout at edge k+TIMEOUT; freeze_clk falls at edge k+TIMEOUT+STRETCH.
- Minimum exchange with one record, STRETCH=2: exch_start edge k → done at edge k+4.

## Structure
- Shared package part_pkg holds:
  - the mission-clock enum (data_clk_0..data_clk_3), also used by the target side;
  - the state enum rcv_state_t;
  - the record type (N-bit packed: wen + data);
  - the NUM_CLOCKS=4 constant.
- Sub-module part_watchdog:
  - parameterised 16-bit counter;
  - clear, enable and expire ports;
  - reused for the wd and rel_cnt counters.
- Slot storage is a 4×N register array inside the top module.

## Test plan
- **Full exchange:**
  - Stimulus: exp_mask=4'hf; records id0=9'h1aa, id1=9'h155, id2=9'h133, id3=9'h1ff, one per cycle.
  - Required: pins wen0=1/i_data0=aa, wen1=1/55, wen2=1/33, up_data=1ff with up_valid pulse; done 3 cycles after the last accept; freeze_clk high throughout.
- **Out of order with duplicate:**
  - Stimulus: exp_mask=4'b0101; records id2=9'h033, id2=9'h044, id0=9'h101.
  - Required: one err_unexp; i_data2=33, wen2=0, wen0=1, i_data0=01; slot1 pins unchanged.
- **Timeout:**
  - Stimulus: TIMEOUT=8, exp_mask=4'b0011, only id0 sent.
  - Required: err_timeout at start+8; no pin change; freeze_clk low at start+10; no done.
- **Busy:**
  - Stimulus: exch_start during RELEASE.
  - Required: err_busy pulse; the original exchange still completes with a single done.
- **Reset mid-COLLECT:**
  - Stimulus: rst_i after id0 is accepted.
  - Required: freeze_clk=0, rx_ready=0, all pins 0 at the reset edge; a following exchange works normally.
- **Completion on the timeout cycle:**
  - Stimulus: TIMEOUT=4, the last record accepted at wd=3.
  - Required: APPLY occurs, no err_timeout, done asserted.
